// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time, drives a simple
// strobe/ack memory port, and returns extended load data or an error flag.
// All handshake, memory-side and response outputs are registered.
module lsu_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] Address,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [XLEN-1:0]   Write_data,
    output logic [XLEN/8-1:0] Write_strb,
    input  logic              Mem_Req_Ack,
    input  logic [XLEN-1:0]   Read_data,
    input  logic              Read_data_Valid,
    output logic              Read_data_Ack,
    output logic [CNT_W-1:0]  cnt_load,
    output logic [CNT_W-1:0]  cnt_store,
    output logic [CNT_W-1:0]  cnt_wait,
    output logic              busy
);

    localparam int NBYTES = XLEN / 8;
    localparam int LSB_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        ST   = 5'b00010,
        LD   = 5'b00100,
        RDW  = 5'b01000,
        RESP = 5'b10000
    } state_t;

    state_t            r_state;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [LSB_W-1:0]  r_off;

    logic              w_err;
    logic [ADDR_W-1:0] w_aligned;
    logic [XLEN-1:0]   w_wdata_rep;
    logic [NBYTES-1:0] w_strb;
    logic [XLEN-1:0]   w_load_data;

    // Copy the low lane of the store operand into every lane of the bus.
    function automatic logic [XLEN-1:0] f_repl(input logic [XLEN-1:0] wdata,
                                               input logic [1:0] size);
        logic [XLEN-1:0] wd;
        int lb;
        wd = '0;
        lb = 1 << size;
        for (int i = 0; i < NBYTES; i++) begin
            wd[8*i +: 8] = wdata[8*(i % lb) +: 8];
        end
        return wd;
    endfunction

    // Enable only the bytes covered by the access starting at the lane offset.
    function automatic logic [NBYTES-1:0] f_strb(input logic [LSB_W-1:0] low,
                                                 input logic [1:0] size);
        logic [NBYTES-1:0] s;
        int off;
        int lb;
        s   = '0;
        off = int'(low);
        lb  = 1 << size;
        for (int i = 0; i < NBYTES; i++) begin
            s[i] = (i >= off) && (i < off + lb);
        end
        return s;
    endfunction

    // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] raw,
                                                 input logic [LSB_W-1:0] low,
                                                 input logic [1:0] size,
                                                 input logic uns);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        logic            sbit;
        int              w;
        sh  = raw >> {low, 3'b000};
        res = sh;
        w   = 8 << size;
        case (size)
            2'd0:    sbit = sh[7];
            2'd1:    sbit = sh[15];
            2'd2:    sbit = sh[31];
            default: sbit = 1'b0;
        endcase
        for (int i = 0; i < XLEN; i++) begin
            if (i >= w) res[i] = ~uns & sbit;
        end
        return res;
    endfunction

    // Decode an incoming request: legality, aligned bus address, store lanes.
    always_comb begin
        w_err = 1'b0;
        case (req_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = req_addr[0];
            2'd2:    w_err = |req_addr[1:0];
            default: w_err = (XLEN == 32) || (|req_addr[2:0]);
        endcase
        w_aligned   = {req_addr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
        w_wdata_rep = f_repl(req_wdata, req_size);
        w_strb      = f_strb(req_addr[LSB_W-1:0], req_size);
    end

    // Extend the returned word using the latched access attributes.
    always_comb begin
        w_load_data = f_extend(Read_data, r_off, r_size, r_uns);
    end

    // Main controller: state, registered outputs and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_size        <= 2'd0;
            r_uns         <= 1'b0;
            r_off         <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            Address       <= '0;
            MemWrite      <= 1'b0;
            MemRead       <= 1'b0;
            Write_data    <= '0;
            Write_strb    <= '0;
            Read_data_Ack <= 1'b0;
            cnt_load      <= '0;
            cnt_store     <= '0;
            cnt_wait      <= '0;
            busy          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_size    <= req_size;
                        r_uns     <= req_unsigned;
                        r_off     <= req_addr[LSB_W-1:0];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        resp_data <= '0;
                        if (w_err) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we) begin
                            r_state    <= ST;
                            resp_err   <= 1'b0;
                            MemWrite   <= 1'b1;
                            Address    <= w_aligned;
                            Write_data <= w_wdata_rep;
                            Write_strb <= w_strb;
                        end else begin
                            r_state  <= LD;
                            resp_err <= 1'b0;
                            MemRead  <= 1'b1;
                            Address  <= w_aligned;
                        end
                    end
                end
                ST: begin
                    if (Mem_Req_Ack) begin
                        r_state    <= RESP;
                        MemWrite   <= 1'b0;
                        Write_strb <= '0;
                        resp_valid <= 1'b1;
                        cnt_store  <= cnt_store + CNT_ONE;
                    end else begin
                        cnt_wait <= cnt_wait + CNT_ONE;
                    end
                end
                LD: begin
                    if (Mem_Req_Ack) begin
                        r_state       <= RDW;
                        MemRead       <= 1'b0;
                        Read_data_Ack <= 1'b1;
                    end else begin
                        cnt_wait <= cnt_wait + CNT_ONE;
                    end
                end
                RDW: begin
                    if (Read_data_Valid) begin
                        r_state       <= RESP;
                        Read_data_Ack <= 1'b0;
                        resp_data     <= w_load_data;
                        resp_valid    <= 1'b1;
                        cnt_load      <= cnt_load + CNT_ONE;
                    end else begin
                        cnt_wait <= cnt_wait + CNT_ONE;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state    <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    req_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    MemWrite      <= 1'b0;
                    MemRead       <= 1'b0;
                    Write_strb    <= '0;
                    Read_data_Ack <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl: a 32-bit instance driven through
// stores, loads, errors, back-pressure and reset, then a 64-bit instance
// against an always-acknowledging memory.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 32-bit instance signals
    logic        req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic        resp_ready = 0;
    logic [31:0] resp_data;
    logic [31:0] Address, Write_data;
    logic        MemWrite, MemRead, Read_data_Ack;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack = 0, Read_data_Valid = 0;
    logic [31:0] Read_data = 0;
    logic [31:0] cnt_load, cnt_store, cnt_wait;

    // 64-bit instance signals; memory side always acknowledges
    logic        req_valid64 = 0, req_we64 = 0, req_unsigned64 = 0;
    logic [1:0]  req_size64 = 0;
    logic [31:0] req_addr64 = 0;
    logic [63:0] req_wdata64 = 0;
    logic        req_ready64, resp_valid64, resp_err64, busy64;
    logic [63:0] resp_data64;
    logic [31:0] Address64;
    logic [63:0] Write_data64;
    logic        MemWrite64, MemRead64, Read_data_Ack64;
    logic [7:0]  Write_strb64;
    logic [31:0] cnt_load64, cnt_store64, cnt_wait64;
    logic        ack64 = 1'b1;
    logic [63:0] rdata64 = 64'h1122_3344_5566_7788;

    int compared   = 0;
    int mismatched = 0;
    int expLoad = 0, expStore = 0, expWait = 0;
    logic [64:0] sb[$];

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .CNT_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .Address(Address),
        .MemWrite(MemWrite), .MemRead(MemRead), .Write_data(Write_data),
        .Write_strb(Write_strb), .Mem_Req_Ack(Mem_Req_Ack), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ack(Read_data_Ack),
        .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_wait(cnt_wait), .busy(busy)
    );

    lsu_ctrl #(.XLEN(64), .ADDR_W(32), .CNT_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
        .req_size(req_size64), .req_unsigned(req_unsigned64), .req_addr(req_addr64),
        .req_wdata(req_wdata64), .resp_valid(resp_valid64), .resp_ready(ack64),
        .resp_data(resp_data64), .resp_err(resp_err64), .Address(Address64),
        .MemWrite(MemWrite64), .MemRead(MemRead64), .Write_data(Write_data64),
        .Write_strb(Write_strb64), .Mem_Req_Ack(ack64), .Read_data(rdata64),
        .Read_data_Valid(ack64), .Read_data_Ack(Read_data_Ack64),
        .cnt_load(cnt_load64), .cnt_store(cnt_store64), .cnt_wait(cnt_wait64), .busy(busy64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete 32-bit transaction: drive, serve memory, hold response, release.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic uns, input logic [31:0] rdata,
                                 input int ackWait, input int respWait,
                                 input logic [31:0] expData, input logic expErr,
                                 input logic [31:0] expWdata, input logic [3:0] expStrb,
                                 input int expLat);
        int lat = 0;
        int waits = 0;
        logic sawWrite = 1'b0;
        logic sawRdAck = 1'b0;
        logic [64:0] exp;
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr;
        req_wdata = wdata; req_unsigned = uns;
        Read_data = rdata; Read_data_Valid = 1'b1; Mem_Req_Ack = 1'b0; resp_ready = 1'b0;
        sb.push_back({expErr, 32'h0, expData});
        tick(); lat = 1;
        req_valid = 1'b0;
        checkOutput({tag, ".strobe"}, 64'({MemWrite, MemRead}),
                    expErr ? 64'd0 : (we ? 64'd2 : 64'd1));
        if (!expErr) checkOutput({tag, ".addr"}, 64'(Address), 64'({addr[31:2], 2'b00}));
        while (resp_valid !== 1'b1 && lat < 40) begin
            if (MemWrite === 1'b1 && !sawWrite) begin
                checkOutput({tag, ".wdata"}, 64'(Write_data), 64'(expWdata));
                checkOutput({tag, ".strb"}, 64'(Write_strb), 64'(expStrb));
                sawWrite = 1'b1;
            end
            if (Read_data_Ack === 1'b1) sawRdAck = 1'b1;
            if (MemWrite === 1'b1 || MemRead === 1'b1) begin
                Mem_Req_Ack = (waits >= ackWait);
                waits++;
            end else begin
                Mem_Req_Ack = 1'b0;
            end
            tick(); lat++;
        end
        Mem_Req_Ack = 1'b0;
        checkOutput({tag, ".respValid"}, 64'(resp_valid), 64'd1);
        checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
        if (we && !expErr) checkOutput({tag, ".wrSeen"}, 64'(sawWrite), 64'd1);
        if (!we && !expErr) checkOutput({tag, ".rdAckSeen"}, 64'(sawRdAck), 64'd1);
        checkOutput({tag, ".idleStrobes"}, 64'({MemWrite, MemRead, Read_data_Ack, Write_strb}), 64'd0);
        if (sb.size() == 0) begin
            checkOutput({tag, ".sbEmpty"}, 64'(sb.size()), 64'd1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        checkOutput({tag, ".data"}, 64'(resp_data), exp[63:0]);
        checkOutput({tag, ".err"}, 64'(resp_err), 64'(exp[64]));
        for (int k = 0; k < respWait; k++) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h7000;
            tick();
            checkOutput({tag, ".holdValid"}, 64'(resp_valid), 64'd1);
            checkOutput({tag, ".holdData"}, 64'(resp_data), exp[63:0]);
            checkOutput({tag, ".holdReady"}, 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput({tag, ".release"}, 64'({resp_valid, req_ready, busy}), 64'b010);
        if (!expErr) begin
            if (we) expStore++;
            else    expLoad++;
            expWait += ackWait;
        end
        checkOutput({tag, ".cntLoad"}, 64'(cnt_load), 64'(expLoad));
        checkOutput({tag, ".cntStore"}, 64'(cnt_store), 64'(expStore));
        checkOutput({tag, ".cntWait"}, 64'(cnt_wait), 64'(expWait));
    endtask

    // One 64-bit transaction against the always-acknowledging memory.
    task automatic applyStimulus64(input string tag, input logic we, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [63:0] wdata,
                                   input logic uns, input logic [63:0] expData,
                                   input logic [63:0] expWdata, input logic [7:0] expStrb);
        int n = 0;
        logic [64:0] exp;
        req_valid64 = 1'b1; req_we64 = we; req_size64 = size; req_addr64 = addr;
        req_wdata64 = wdata; req_unsigned64 = uns;
        sb.push_back({1'b0, expData});
        tick();
        req_valid64 = 1'b0;
        checkOutput({tag, ".addr"}, 64'(Address64), 64'({addr[31:3], 3'b000}));
        if (we) begin
            checkOutput({tag, ".memWrite"}, 64'(MemWrite64), 64'd1);
            checkOutput({tag, ".wdata"}, Write_data64, expWdata);
            checkOutput({tag, ".strb"}, 64'(Write_strb64), 64'(expStrb));
        end else begin
            checkOutput({tag, ".memRead"}, 64'(MemRead64), 64'd1);
        end
        while (resp_valid64 !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        checkOutput({tag, ".respValid"}, 64'(resp_valid64), 64'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 65'd0;
        checkOutput({tag, ".data"}, resp_data64, exp[63:0]);
        checkOutput({tag, ".err"}, 64'(resp_err64), 64'(exp[64]));
        tick();
        checkOutput({tag, ".ready"}, 64'(req_ready64), 64'd1);
    endtask

    initial begin
        $display("[TB] lsu_ctrl bench start");
        rst = 1'b1;
        tick(); tick();
        checkOutput("reset.ready", 64'({req_ready, busy, resp_valid}), 64'b100);
        checkOutput("reset.mem", 64'({MemWrite, MemRead, Read_data_Ack, Write_strb}), 64'd0);
        checkOutput("reset.cnt", 64'(cnt_load | cnt_store | cnt_wait), 64'd0);
        checkOutput("reset.data", 64'({resp_data, Address}), 64'd0);
        checkOutput("reset.ready64", 64'({req_ready64, busy64}), 64'b10);
        rst = 1'b0;
        tick();

        // signed byte load, same-cycle acks
        applyStimulus("ldb", 1'b0, 2'd0, 32'h1003, 32'h0, 1'b0, 32'h80FF_FFFF,
                      0, 0, 32'hFFFF_FF80, 1'b0, 32'h0, 4'h0, 3);
        // half store with three wait cycles
        applyStimulus("sth", 1'b1, 2'd1, 32'h2002, 32'h0000_BEEF, 1'b0, 32'h0,
                      3, 0, 32'h0, 1'b0, 32'hBEEF_BEEF, 4'b1100, 5);
        // misaligned word load
        applyStimulus("ldwMis", 1'b0, 2'd2, 32'h1002, 32'h0, 1'b0, 32'h1234_5678,
                      0, 0, 32'h0, 1'b1, 32'h0, 4'h0, 1);
        // dword size is illegal at 32 bits
        applyStimulus("ldd32", 1'b0, 2'd3, 32'h1000, 32'h0, 1'b0, 32'h1234_5678,
                      0, 0, 32'h0, 1'b1, 32'h0, 4'h0, 1);
        // misaligned half store
        applyStimulus("sthMis", 1'b1, 2'd1, 32'h2001, 32'h1111, 1'b0, 32'h0,
                      0, 0, 32'h0, 1'b1, 32'h0, 4'h0, 1);
        // byte store at lane 1
        applyStimulus("stb", 1'b1, 2'd0, 32'h3001, 32'h1234_5678, 1'b0, 32'h0,
                      0, 0, 32'h0, 1'b0, 32'h7878_7878, 4'b0010, 2);
        // word store with response back-pressure
        applyStimulus("stw", 1'b1, 2'd2, 32'h4000, 32'hDEAD_BEEF, 1'b0, 32'h0,
                      1, 4, 32'h0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 3);
        // signed half load from upper lane, two wait cycles
        applyStimulus("ldh", 1'b0, 2'd1, 32'h2002, 32'h0, 1'b0, 32'h8001_0000,
                      2, 0, 32'hFFFF_8001, 1'b0, 32'h0, 4'h0, 5);
        // unsigned byte load from lane 1, held response
        applyStimulus("ldbu", 1'b0, 2'd0, 32'h1001, 32'h0, 1'b1, 32'h0000_AB00,
                      0, 4, 32'h0000_00AB, 1'b0, 32'h0, 4'h0, 3);

        // reset while waiting for read data
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h1000;
        Mem_Req_Ack = 1'b1; Read_data_Valid = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("rstRdw.ack", 64'(Read_data_Ack), 64'd1);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rstRdw.idle", 64'({req_ready, busy, Read_data_Ack, resp_valid, MemRead}), 64'b10000);
        checkOutput("rstRdw.cnt", 64'(cnt_load | cnt_store | cnt_wait), 64'd0);
        expLoad = 0; expStore = 0; expWait = 0;
        tick();
        rst = 1'b0;
        Mem_Req_Ack = 1'b0;
        tick();
        applyStimulus("stPostRst", 1'b1, 2'd2, 32'h5004, 32'hCAFE_F00D, 1'b0, 32'h0,
                      0, 0, 32'h0, 1'b0, 32'hCAFE_F00D, 4'b1111, 2);

        // 64-bit instance
        applyStimulus64("ld64d", 1'b0, 2'd3, 32'h08, 64'h0, 1'b0,
                        64'h1122_3344_5566_7788, 64'h0, 8'h0);
        applyStimulus64("ld64wu", 1'b0, 2'd2, 32'h0C, 64'h0, 1'b1,
                        64'h0000_0000_1122_3344, 64'h0, 8'h0);
        applyStimulus64("ld64b", 1'b0, 2'd0, 32'h00, 64'h0, 1'b0,
                        64'hFFFF_FFFF_FFFF_FF88, 64'h0, 8'h0);
        applyStimulus64("st64d", 1'b1, 2'd3, 32'h10, 64'h0123_4567_89AB_CDEF, 1'b0,
                        64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF);
        applyStimulus64("st64b", 1'b1, 2'd0, 32'h13, 64'h5A, 1'b0,
                        64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 8'b0000_1000);
        checkOutput("cnt64", 64'({cnt_load64[7:0], cnt_store64[7:0], cnt_wait64[7:0]}), 64'h030200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
